// File: rtl/shiftreg_seq.sv
// Serializes a word MSB-first into a DEPTH-stage shift register, flushes it with zeros and recaptures the returned stream.
// The result is valid WIDTH+DEPTH+1 cycles after input acceptance and is held until out_ready, followed by GAP idle cycles.
module shiftreg_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             s_out,
  output logic             shift_en,
  input  logic             s_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mismatch,
  output logic             busy
);

  localparam int TOTAL = WIDTH + DEPTH;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int GW    = $clog2(GAP + 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TOTAL);
  localparam logic [CW-1:0] CAP_FIRST = CW'(DEPTH + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             in_ready_q, in_ready_d;
  logic             s_out_q, s_out_d;
  logic             shift_en_q, shift_en_d;
  logic             out_valid_q, out_valid_d;
  logic             mismatch_q, mismatch_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   cap_ext;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] sh_next;

  // Capture shifts LSB-in, so the first returned bit lands in the MSB.
  assign cap_ext  = {cap_q, s_in};
  assign cap_next = cap_ext[WIDTH-1:0];
  assign sh_next  = sh_q << 1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    tx_d        = tx_q;
    sh_d        = sh_q;
    cap_d       = cap_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    s_out_d     = s_out_q;
    shift_en_d  = shift_en_q;
    out_valid_d = out_valid_q;
    mismatch_d  = mismatch_q;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          tx_d       = in_data;
          sh_d       = in_data;
          cap_d      = '0;
          cnt_d      = CW'(1);
          s_out_d    = in_data[WIDTH-1];
          shift_en_d = 1'b1;
          in_ready_d = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d    = S_IDLE;
          shift_en_d = 1'b0;
          s_out_d    = 1'b0;
          in_ready_d = 1'b1;
        end else begin
          if (cnt_q >= CAP_FIRST) cap_d = cap_next;
          if (cnt_q == CNT_LAST) begin
            state_d     = S_DONE;
            shift_en_d  = 1'b0;
            s_out_d     = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = cap_d;
            mismatch_d  = (cap_d != tx_q);
          end else begin
            cnt_d   = cnt_q + CW'(1);
            sh_d    = sh_next;
            s_out_d = sh_next[WIDTH-1];
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          mismatch_d  = 1'b0;
          in_ready_d  = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          mismatch_d  = 1'b0;
          if (GAP == 0) begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
          end else begin
            state_d = S_GAP;
            gcnt_d  = GW'(1);
          end
        end
      end
      S_GAP: begin
        if (gcnt_q >= GAP_LAST) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      tx_q        <= '0;
      sh_q        <= '0;
      cap_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      s_out_q     <= 1'b0;
      shift_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      tx_q        <= tx_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      s_out_q     <= s_out_d;
      shift_en_q  <= shift_en_d;
      out_valid_q <= out_valid_d;
      mismatch_q  <= mismatch_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign s_out     = s_out_q;
  assign shift_en  = shift_en_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign mismatch  = mismatch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shiftreg_seq.sv
// Directed bench for shiftreg_seq with a 4-stage loopback register model on the serial side.
module tb_shiftreg_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       abort = 1'b0;
  logic       s_out;
  logic       shift_en;
  logic       s_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       mismatch;
  logic       busy;

  logic       loop_en = 1'b1;
  logic [3:0] sr = 4'h0;

  int tests = 0;
  int fails = 0;

  shiftreg_seq #(.WIDTH(8), .DEPTH(4), .GAP(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .s_out     (s_out),
    .shift_en  (shift_en),
    .s_in      (s_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mismatch  (mismatch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // External serial chain: DEPTH-stage register clocked only while shift_en is high.
  always @(posedge clk) begin
    if (shift_en) sr <= {sr[2:0], s_out};
  end
  assign s_in = loop_en ? sr[3] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_rdy_wait"}, in_ready, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_shift_en"}, shift_en, 0);
    check({tag, "_s_out"}, s_out, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One full transfer; hold = cycles out_ready stays low once out_valid is up.
  task automatic run_word(input logic [7:0] d, input logic [7:0] exp_d, input logic exp_mm,
                          input int hold, input string tag);
    int en_cnt = 0;
    int ov_cyc = 0;
    wait_ready(tag);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 40 && ov_cyc == 0; k++) begin
      if (shift_en) en_cnt++;
      if (out_valid) ov_cyc = k;
      else @(negedge clk);
    end
    check({tag, "_shift_cycles"}, en_cnt, 12);
    check({tag, "_valid_cycle"}, ov_cyc, 13);
    check({tag, "_out_data"}, out_data, exp_d);
    check({tag, "_mismatch"}, mismatch, exp_mm);
    check({tag, "_busy"}, busy, 1);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_data"}, out_data, exp_d);
      check({tag, "_hold_mm"}, mismatch, exp_mm);
      check({tag, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_gap1_rdy"}, in_ready, 0);
    @(negedge clk);
    check({tag, "_gap2_rdy"}, in_ready, 0);
    @(negedge clk);
    check({tag, "_idle_rdy"}, in_ready, 1);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int ov_seen;

    // Reset state
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_rel_rdy", in_ready, 0);
    @(negedge clk);
    check("rst_first_edge_rdy", in_ready, 1);
    check("rst_first_edge_busy", busy, 0);

    // Loopback, tied-zero return, and held output
    loop_en = 1'b1;
    run_word(8'hA5, 8'hA5, 1'b0, 0, "loop_a5");
    loop_en = 1'b0;
    run_word(8'h3C, 8'h00, 1'b1, 0, "tie0_3c");
    run_word(8'h00, 8'h00, 1'b0, 0, "tie0_00");
    loop_en = 1'b1;
    run_word(8'hFF, 8'hFF, 1'b0, 5, "hold_ff");

    // Asynchronous reset during SHIFT cycle 5
    wait_ready("arst");
    in_data  = 8'hC3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) @(negedge clk);
    check("arst_pre_shift_en", shift_en, 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_rel_rdy", in_ready, 0);
    @(negedge clk);
    check("arst_edge_rdy", in_ready, 1);
    ov_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("arst_no_output", ov_seen, 0);

    // Abort during SHIFT cycle 7, then a clean word afterwards
    wait_ready("abort");
    in_data  = 8'h6E;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 2; k <= 7; k++) @(negedge clk);
    check("abort_pre_shift_en", shift_en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_shift_en", shift_en, 0);
    check("abort_s_out", s_out, 0);
    check("abort_busy", busy, 0);
    check("abort_rdy", in_ready, 1);
    ov_seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) ov_seen++;
      @(negedge clk);
    end
    check("abort_no_output", ov_seen, 0);
    run_word(8'h81, 8'h81, 1'b0, 0, "after_abort_81");

    // Back-to-back words with in_valid held high
    wait_ready("b2b");
    in_data   = 8'h12;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      case (c)
        1: check("b2b_c1_rdy", in_ready, 0);
        13: begin
          check("b2b_w0_valid", out_valid, 1);
          check("b2b_w0_data", out_data, 8'h12);
          check("b2b_w0_mm", mismatch, 0);
          in_data = 8'h34;
        end
        14: check("b2b_c14_valid", out_valid, 0);
        15: check("b2b_c15_rdy", in_ready, 0);
        16: check("b2b_c16_rdy", in_ready, 1);
        17: begin
          check("b2b_c17_rdy", in_ready, 0);
          check("b2b_c17_busy", busy, 1);
          in_valid = 1'b0;
        end
        28: check("b2b_c28_valid", out_valid, 0);
        29: begin
          check("b2b_w1_valid", out_valid, 1);
          check("b2b_w1_data", out_data, 8'h34);
          check("b2b_w1_mm", mismatch, 0);
        end
        30: check("b2b_c30_valid", out_valid, 0);
        default: ;
      endcase
    end
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shiftreg_seq.md
# shiftreg_seq

Sequencer that owns a serial-in/serial-out shift register of DEPTH stages. Accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first into the register with a shift enable. Flushes the word through the register with zeros and recaptures the returned serial stream into a parallel word. Presents that word with a pass/fail compare flag over a second valid/ready handshake. Used for loopback self-test and for loading and unloading serial scan/config chains.

## Interface
- WIDTH, 8, word length in bits (≥1)
- DEPTH, 4, stage count of the attached shift register (≥1)
- GAP, 2, idle cycles enforced between output acceptance and the next in_ready (≥0)

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_data  in  WIDTH  word to serialize
- in_valid  in  1  in_data is valid
- in_ready  out  1  sequencer can accept a word
- abort  in  1  synchronous abort of the current transfer
- s_out  out  1  serial bit to shift register s_in
- shift_en  out  1  shift register clock enable
- s_in  in  1  serial bit returned from shift register s_out
- out_data  out  WIDTH  recaptured word
- out_valid  out  1  out_data and mismatch are valid
- out_ready  in  1  consumer accepts out_data
- mismatch  out  1  out_data != word sent
- busy  out  1  state is not IDLE

## Operation
- All outputs are registered. While reset is high, every output is 0, including in_ready; the state is IDLE.
- in_ready rises on the first clock edge after reset deasserts.
- States: IDLE, SHIFT, DONE, GAP.
- IDLE:
  - in_ready=1, busy=0.
  - On an edge with in_valid&&in_ready: latch in_data into tx register, clear capture register and counter.
  - At that same edge: s_out<=in_data[WIDTH-1], shift_en<=1, in_ready<=0, go to SHIFT.
- SHIFT:
  - Lasts exactly WIDTH+DEPTH cycles, counted 1..WIDTH+DEPTH. shift_en=1 throughout.
  - Cycle c≤WIDTH: s_out = tx bit WIDTH-c (MSB first).
  - Cycle c>WIDTH: s_out=0 (flush).
  - Cycle c in DEPTH+1..DEPTH+WIDTH: s_in sampled at end of cycle and shifted into the capture register LSB-in. After the last sample, capture[WIDTH-1] holds the first bit returned.
  - Counter width is clog2(WIDTH+DEPTH+1). At c=WIDTH+DEPTH go to DONE.
- DONE:
  - shift_en=0, s_out=0.
  - out_valid=1 and out_data=capture; mismatch=(capture != tx). Both are held stable until out_valid&&out_ready.
  - On acceptance: out_valid<=0, go to GAP. If GAP=0, go directly to IDLE.
- GAP: GAP cycles with in_ready=0, then IDLE.
- abort high on an edge in SHIFT or DONE:
  - Go to IDLE at that edge; shift_en, s_out, out_valid and mismatch <=0.
  - No output word is produced; the external register contents are don't-care.
- abort in IDLE or GAP: no effect.
- abort and an input handshake on the same edge in IDLE: the handshake wins.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No partial word is ever presented.
- in_data and in_valid are ignored outside IDLE. out_ready is ignored outside DONE.

## Timing
- Handshake edge = edge 0. shift_en is high during cycles 1..WIDTH+DEPTH.
- out_valid rises in cycle WIDTH+DEPTH+1 (cycle 13 for defaults).
- If out_ready is held high: out accepted at end of cycle 13, GAP in cycles 14–15, in_ready=1 in cycle 16.
- Minimum word period = WIDTH+DEPTH+2+GAP cycles.
- Bit sent in cycle c returns on s_in in cycle c+DEPTH (attached register latency DEPTH).
- Back-to-back: in_valid held high with new data is accepted on the first edge with in_ready=1. There are no bubbles beyond GAP.

## Test plan
- Reset pulse then loopback s_out→DEPTH-stage shiftreg→s_in, send 0xA5 → shift_en high exactly 12 cycles; out_valid in cycle 13; out_data=0xA5, mismatch=0.
- Same setup, s_in tied 0, send 0x3C → out_data=0x00, mismatch=1. Then send 0x00 → mismatch=0.
- Send 0xFF with out_ready low for 5 cycles after out_valid → out_data, out_valid and mismatch stable all 5 cycles; in_ready stays 0 until 2 cycles after acceptance.
- Assert reset asynchronously mid-SHIFT (cycle 5) → all outputs 0 before next edge; in_ready=1 one edge after release; no out_valid ever issued for that word.
- abort in cycle 7 of SHIFT → IDLE next cycle, shift_en=0, no out_valid. Then send 0x81 → correct 0x81 recaptured (flush clears stale bits).
- in_valid held high with words 0x12, 0x34, out_ready=1 → accepts at edges 0 and 16; outputs 0x12 then 0x34, each mismatch=0.
